// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - register offsets, status bit positions and IO window base for mmio_ram
package mmio_pkg;

    // Register offsets relative to IO_BASE
    localparam int OFF_EVT_STATUS = 0;
    localparam int OFF_EVT_DATA   = 1;
    localparam int OFF_ACK        = 2;
    localparam int OFF_IN         = 3;

    // EVT_STATUS bit positions
    localparam int STAT_NONEMPTY  = 0;
    localparam int STAT_OVERFLOW  = 1;
    localparam int STAT_COUNT_LSB = 2;

    // OUT ports follow the IN ports
    function automatic int off_out(input int n_in);
        return OFF_IN + n_in;
    endfunction

    // The IO window sits at the very top of the address space
    function automatic int io_base(input int aw, input int n_in, input int n_out);
        return (1 << aw) - n_out - n_in - 3;
    endfunction

endpackage

// File: rtl/mmio_ram_if.sv
// rtl/mmio_ram_if.sv - CPU-side data bus (address, write data, strobes, read data)
interface mmio_ram_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic [AW-1:0] ADDR;
    logic [DW-1:0] DATA;
    logic          MW;
    logic          RD;
    logic [DW-1:0] Q;

    modport master (output ADDR, output DATA, output MW, output RD, input Q);
    modport slave  (input ADDR, input DATA, input MW, input RD, output Q);
endinterface

// File: rtl/mmio_evq.sv
// rtl/mmio_evq.sv - action mailbox FIFO with sticky overflow flag
module mmio_evq #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    input  logic          i_ovf_clr,
    output logic [DW-1:0] o_head,
    output logic [CW:0]   o_count,
    output logic          o_full,
    output logic          o_empty,
    output logic          o_overflow
);

    logic [DW-1:0] r_mem [0:DEPTH-1];
    logic [CW-1:0] r_wptr;
    logic [CW-1:0] r_rptr;
    logic [CW:0]   r_count;
    logic          r_overflow;
    logic          w_do_pop;
    logic          w_do_push;

    assign o_full     = (r_count == (CW+1)'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_overflow = r_overflow;
    assign o_head     = o_empty ? '0 : r_mem[r_rptr];

    // A pop frees a slot this cycle, so a push into a full queue still lands
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Storage: when full, the written slot is the head being popped, read before the edge
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // Pointers, occupancy and sticky overflow; a new drop outranks a clear
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (i_push && !w_do_push) begin
                r_overflow <= 1'b1;
            end else if (i_ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mmio_ram.sv
// rtl/mmio_ram.sv - data RAM with top-of-space MMIO window; MMIO_RAM_DISP_EN exports the display window
module mmio_ram
    import mmio_pkg::*;
#(
    parameter int AW        = 8,
    parameter int DW        = 8,
    parameter int N_IN      = 2,
    parameter int N_OUT     = 6,
    parameter int EVQ_DEPTH = 4,
    parameter int DISP_BASE = 64,
    parameter int DISP_LEN  = 64
) (
    input  logic                   CLK,
    input  logic                   RESET,
    mmio_ram_if.slave              bus,
    input  logic [N_IN*DW-1:0]     IN_BUS,
    output logic [N_OUT*DW-1:0]    OUT_BUS,
    input  logic [DW-1:0]          ACTION,
    input  logic                   ACTION_VALID,
    output logic [DW-1:0]          ACK,
    output logic                   ACK_PULSE,
    output logic [DISP_LEN*DW-1:0] DISP
);

    localparam int            IO_BASE  = io_base(AW, N_IN, N_OUT);
    localparam int            CW       = $clog2(EVQ_DEPTH);
    localparam logic [AW-1:0] A_STATUS = AW'(IO_BASE + OFF_EVT_STATUS);
    localparam logic [AW-1:0] A_DATA   = AW'(IO_BASE + OFF_EVT_DATA);
    localparam logic [AW-1:0] A_ACK    = AW'(IO_BASE + OFF_ACK);
    localparam logic [AW-1:0] A_IN     = AW'(IO_BASE + OFF_IN);
    localparam logic [AW-1:0] A_OUT    = AW'(IO_BASE + off_out(N_IN));

    logic [DW-1:0]       r_mem [0:IO_BASE-1];
    logic [N_OUT*DW-1:0] r_out;
    logic [DW-1:0]       r_ack;
    logic                r_ack_pulse;

    logic          w_is_ram;
    logic          w_pop;
    logic          w_ovf_clr;
    logic [DW-1:0] w_head;
    logic [CW:0]   w_count;
    logic          w_full;
    logic          w_empty;
    logic          w_overflow;
    logic [DW-1:0] w_status;
    logic [DW-1:0] w_q;
    logic          w_unused;

    assign w_is_ram  = (bus.ADDR < A_STATUS);
    assign w_pop     = bus.RD && !bus.MW && (bus.ADDR == A_DATA);
    assign w_ovf_clr = bus.MW && (bus.ADDR == A_STATUS) && bus.DATA[STAT_OVERFLOW];
    assign w_unused  = &{1'b0, w_full};

    mmio_evq #(
        .DW    (DW),
        .DEPTH (EVQ_DEPTH)
    ) u_evq (
        .i_clk      (CLK),
        .i_rst      (RESET),
        .i_push     (ACTION_VALID),
        .i_data     (ACTION),
        .i_pop      (w_pop),
        .i_ovf_clr  (w_ovf_clr),
        .o_head     (w_head),
        .o_count    (w_count),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_overflow (w_overflow)
    );

    // RAM array; deliberately untouched by RESET
    always_ff @(posedge CLK) begin
        if (bus.MW && w_is_ram) begin
            r_mem[bus.ADDR] <= bus.DATA;
        end
    end

    // OUT port registers, ACK value and its one-cycle-per-write pulse
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_out       <= '0;
            r_ack       <= '0;
            r_ack_pulse <= 1'b0;
        end else begin
            r_ack_pulse <= bus.MW && (bus.ADDR == A_ACK);
            if (bus.MW && (bus.ADDR == A_ACK)) begin
                r_ack <= bus.DATA;
            end
            for (int i = 0; i < N_OUT; i++) begin
                if (bus.MW && (bus.ADDR == A_OUT + AW'(i))) begin
                    r_out[i*DW +: DW] <= bus.DATA;
                end
            end
        end
    end

    // Pack the mailbox state into the EVT_STATUS word
    always_comb begin
        w_status                            = '0;
        w_status[STAT_NONEMPTY]             = !w_empty;
        w_status[STAT_OVERFLOW]             = w_overflow;
        w_status[STAT_COUNT_LSB +: CW+1]    = w_count;
    end

    // Combinational read mux; writes always read back as zero
    always_comb begin
        w_q = '0;
        if (!bus.MW) begin
            if (w_is_ram) begin
                w_q = r_mem[bus.ADDR];
            end else if (bus.ADDR == A_STATUS) begin
                w_q = w_status;
            end else if (bus.ADDR == A_DATA) begin
                w_q = w_head;
            end else if (bus.ADDR == A_ACK) begin
                w_q = r_ack;
            end
            for (int i = 0; i < N_IN; i++) begin
                if (bus.ADDR == A_IN + AW'(i)) begin
                    w_q = IN_BUS[i*DW +: DW];
                end
            end
            for (int i = 0; i < N_OUT; i++) begin
                if (bus.ADDR == A_OUT + AW'(i)) begin
                    w_q = r_out[i*DW +: DW];
                end
            end
        end
    end

    assign bus.Q     = w_q;
    assign OUT_BUS   = r_out;
    assign ACK       = r_ack;
    assign ACK_PULSE = r_ack_pulse;

`ifdef MMIO_RAM_DISP_EN
    for (genvar k = 0; k < DISP_LEN; k++) begin : g_disp
        assign DISP[k*DW +: DW] = r_mem[DISP_BASE + k];
    end
`else
    assign DISP = '0;
`endif

endmodule

// File: tb/tb_mmio_ram.sv
// tb/tb_mmio_ram.sv - scoreboard bench for mmio_ram
module tb_mmio_ram;

    localparam logic [7:0] A_STATUS = 8'd245;
    localparam logic [7:0] A_DATA   = 8'd246;
    localparam logic [7:0] A_ACK    = 8'd247;
    localparam logic [7:0] A_IN0    = 8'd248;
    localparam logic [7:0] A_IN1    = 8'd249;
    localparam logic [7:0] A_OUT0   = 8'd250;

    logic         CLK = 1'b0;
    logic         RESET;
    logic [15:0]  IN_BUS;
    logic [47:0]  OUT_BUS;
    logic [7:0]   ACTION;
    logic         ACTION_VALID;
    logic [7:0]   ACK;
    logic         ACK_PULSE;
    logic [511:0] DISP;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb_q[$];
    logic       m_ovf = 1'b0;
    logic [7:0] exp_v;

    always #5 CLK = ~CLK;

    mmio_ram_if #(.AW(8), .DW(8)) bus ();

    mmio_ram #(
        .AW(8), .DW(8), .N_IN(2), .N_OUT(6), .EVQ_DEPTH(4), .DISP_BASE(64), .DISP_LEN(64)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .bus          (bus),
        .IN_BUS       (IN_BUS),
        .OUT_BUS      (OUT_BUS),
        .ACTION       (ACTION),
        .ACTION_VALID (ACTION_VALID),
        .ACK          (ACK),
        .ACK_PULSE    (ACK_PULSE),
        .DISP         (DISP)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        bus.ADDR = a;
        bus.DATA = d;
        bus.MW   = 1'b1;
        tick();
        bus.MW   = 1'b0;
    endtask

    // Drives one action and records in the scoreboard what the mailbox should hold
    task automatic act_push(input logic [7:0] v);
        ACTION       = v;
        ACTION_VALID = 1'b1;
        if (sb_q.size() < 4) sb_q.push_back(v);
        else m_ovf = 1'b1;
        tick();
        ACTION_VALID = 1'b0;
    endtask

    function automatic logic [7:0] exp_status();
        return {3'b000, 3'(sb_q.size()), m_ovf, (sb_q.size() != 0)};
    endfunction

    task automatic test_reset();
        bus.ADDR = A_STATUS;
        #1;
        checks++;
        if (bus.Q !== 8'h00) begin errors++; $display("FAIL reset_status got %h exp 00", bus.Q); end
        checks++;
        if (OUT_BUS !== 48'h0) begin errors++; $display("FAIL reset_out got %h exp 0", OUT_BUS); end
        checks++;
        if (ACK_PULSE !== 1'b0 || ACK !== 8'h00) begin
            errors++; $display("FAIL reset_ack got %b/%h exp 0/00", ACK_PULSE, ACK);
        end
    endtask

    task automatic test_ram();
        logic [7:0] ram_exp[$];
        logic [7:0] ram_adr[$];
        bus.ADDR = 8'd10;
        bus.DATA = 8'h5A;
        bus.MW   = 1'b1;
        #1;
        checks++;
        if (bus.Q !== 8'h00) begin errors++; $display("FAIL q_during_write got %h exp 00", bus.Q); end
        tick();
        bus.MW = 1'b0;
        #1;
        checks++;
        if (bus.Q !== 8'h5A) begin errors++; $display("FAIL ram_10 got %h exp 5a", bus.Q); end
        for (int i = 0; i < 4; i++) begin
            ram_adr.push_back(8'(20 + 37 * i));
            ram_exp.push_back(8'($urandom_range(0, 255)));
            bus_write(ram_adr[i], ram_exp[i]);
        end
        while (ram_adr.size() != 0) begin
            bus.ADDR = ram_adr.pop_front();
            exp_v    = ram_exp.pop_front();
            #1;
            checks++;
            if (bus.Q !== exp_v) begin errors++; $display("FAIL ram_rw addr %0d got %h exp %h", bus.ADDR, bus.Q, exp_v); end
        end
        bus_write(A_OUT0, 8'h33);
        bus_write(A_OUT0 + 8'd5, 8'hC5);
        checks++;
        if (OUT_BUS !== 48'hC5_00_00_00_00_33) begin errors++; $display("FAIL out_bus got %h exp c50000000033", OUT_BUS); end
        bus.ADDR = A_OUT0;
        #1;
        checks++;
        if (bus.Q !== 8'h33) begin errors++; $display("FAIL out_readback got %h exp 33", bus.Q); end
        bus.ADDR = 8'd10;
        #1;
        checks++;
        if (bus.Q !== 8'h5A) begin errors++; $display("FAIL ram_after_io got %h exp 5a", bus.Q); end
        bus_write(A_IN0, 8'hFF);
        bus.ADDR = A_IN0;
        #1;
        checks++;
        if (bus.Q !== 8'hA1) begin errors++; $display("FAIL in0 got %h exp a1", bus.Q); end
        bus.ADDR = A_IN1;
        #1;
        checks++;
        if (bus.Q !== 8'hB2) begin errors++; $display("FAIL in1 got %h exp b2", bus.Q); end
    endtask

    task automatic test_queue_overflow();
        for (int i = 1; i <= 5; i++) act_push(8'(i * 8'h11));
        bus.ADDR = A_STATUS;
        #1;
        checks++;
        if (bus.Q !== exp_status()) begin errors++; $display("FAIL status_full got %h exp %h", bus.Q, exp_status()); end
        for (int i = 0; i < 5; i++) begin
            bus.ADDR = A_DATA;
            bus.RD   = 1'b1;
            #1;
            exp_v = (sb_q.size() != 0) ? sb_q.pop_front() : 8'h00;
            checks++;
            if (bus.Q !== exp_v) begin errors++; $display("FAIL pop_%0d got %h exp %h", i, bus.Q, exp_v); end
            tick();
            bus.RD = 1'b0;
        end
        bus.ADDR = A_STATUS;
        #1;
        checks++;
        if (bus.Q !== exp_status()) begin errors++; $display("FAIL status_drained got %h exp %h", bus.Q, exp_status()); end
    endtask

    task automatic test_ack();
        int pulses;
        pulses   = 0;
        bus.ADDR = A_ACK;
        bus.DATA = 8'h01;
        bus.MW   = 1'b1;
        #1;
        checks++;
        if (ACK_PULSE !== 1'b0) begin errors++; $display("FAIL ack_pulse_early got %b exp 0", ACK_PULSE); end
        tick();
        pulses += int'(ACK_PULSE);
        tick();
        bus.MW = 1'b0;
        pulses += int'(ACK_PULSE);
        repeat (3) begin
            tick();
            pulses += int'(ACK_PULSE);
        end
        checks++;
        if (pulses != 2) begin errors++; $display("FAIL ack_pulse_len got %0d exp 2", pulses); end
        checks++;
        if (ACK !== 8'h01 || bus.Q !== 8'h01) begin
            errors++; $display("FAIL ack_value got %h/%h exp 01/01", ACK, bus.Q);
        end
        bus_write(A_STATUS, 8'h02);
        m_ovf    = 1'b0;
        bus.ADDR = A_STATUS;
        #1;
        checks++;
        if (bus.Q !== exp_status()) begin errors++; $display("FAIL ovf_clear got %h exp %h", bus.Q, exp_status()); end
    endtask

    task automatic test_push_pop_full();
        for (int i = 0; i < 4; i++) act_push(8'hA0 + 8'(i));
        ACTION       = 8'hA4;
        ACTION_VALID = 1'b1;
        bus.ADDR     = A_DATA;
        bus.RD       = 1'b1;
        #1;
        exp_v = sb_q.pop_front();
        sb_q.push_back(8'hA4);
        checks++;
        if (bus.Q !== exp_v) begin errors++; $display("FAIL simul_head got %h exp %h", bus.Q, exp_v); end
        tick();
        ACTION_VALID = 1'b0;
        bus.RD       = 1'b0;
        bus.ADDR     = A_STATUS;
        #1;
        checks++;
        if (bus.Q !== exp_status()) begin errors++; $display("FAIL simul_status got %h exp %h", bus.Q, exp_status()); end
        while (sb_q.size() != 0) begin
            bus.ADDR = A_DATA;
            bus.RD   = 1'b1;
            #1;
            exp_v = sb_q.pop_front();
            checks++;
            if (bus.Q !== exp_v) begin errors++; $display("FAIL simul_drain got %h exp %h", bus.Q, exp_v); end
            tick();
            bus.RD = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        act_push(8'h66);
        bus_write(A_OUT0 + 8'd1, 8'h77);
        RESET        = 1'b1;
        bus.ADDR     = A_OUT0 + 8'd2;
        bus.DATA     = 8'h99;
        bus.MW       = 1'b1;
        ACTION       = 8'h88;
        ACTION_VALID = 1'b1;
        tick();
        RESET        = 1'b0;
        bus.MW       = 1'b0;
        ACTION_VALID = 1'b0;
        sb_q.delete();
        m_ovf        = 1'b0;
        bus.ADDR     = A_STATUS;
        #1;
        checks++;
        if (bus.Q !== exp_status() || OUT_BUS !== 48'h0 || ACK !== 8'h00) begin
            errors++; $display("FAIL mid_reset got %h/%h/%h exp %h/0/00", bus.Q, OUT_BUS, ACK, exp_status());
        end
        bus.ADDR = 8'd10;
        #1;
        checks++;
        if (bus.Q !== 8'h5A) begin errors++; $display("FAIL ram_survives_reset got %h exp 5a", bus.Q); end
    endtask

    task automatic test_disp();
        bus_write(8'd64, 8'h41);
        bus_write(8'd127, 8'h7E);
        checks++;
`ifdef MMIO_RAM_DISP_EN
        if (DISP[7:0] !== 8'h41 || DISP[511:504] !== 8'h7E) begin
            errors++; $display("FAIL disp got %h/%h exp 41/7e", DISP[7:0], DISP[511:504]);
        end
`else
        if (DISP !== 512'h0) begin errors++; $display("FAIL disp_off got nonzero exp 0"); end
`endif
    endtask

    initial begin
        RESET        = 1'b1;
        IN_BUS       = 16'hB2A1;
        ACTION       = 8'h00;
        ACTION_VALID = 1'b0;
        bus.ADDR     = 8'h00;
        bus.DATA     = 8'h00;
        bus.MW       = 1'b0;
        bus.RD       = 1'b0;
        repeat (2) tick();
        RESET = 1'b0;
        test_reset();
        test_ram();
        test_queue_overflow();
        test_ack();
        test_push_pop_full();
        test_reset_mid();
        test_disp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
